// File: rtl/pipe_reg_skid_pkg.sv
// rtl/pipe_reg_skid_pkg.sv - shared occupancy encodings and reset constants for pipeline stage registers
package pipe_reg_skid_pkg;

   // Occupancy of a two-entry stage: nothing held, main only, main plus skid
   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_FULL  = 2'd2
   } occ_e;

   // Default program-counter value a PC stage comes out of reset holding
   localparam logic [31:0] PC_RESET = 32'h00400030;

endpackage

// File: rtl/pipe_sat_counter.sv
// rtl/pipe_sat_counter.sv - saturating event counter, cleared only by reset
module pipe_sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   // Count up on inc, sticking at all-ones rather than wrapping
   always_ff @(posedge CLK) begin
      if (RST) begin
         count <= '0;
      end else if (inc && (count != {CNT_W{1'b1}})) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/pipe_reg_skid.sv
// rtl/pipe_reg_skid.sv - pipeline stage register with valid/ready handshake, 2-entry skid, flush and stall counter
module pipe_reg_skid
   import pipe_reg_skid_pkg::*;
#(
   parameter int          WIDTH       = 32,
   parameter logic [31:0] RESET_VAL   = PC_RESET,
   parameter logic        RESET_VALID = 1'b1,
   parameter int          CNT_W       = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             Stall,
   input  logic             Flush,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic [CNT_W-1:0] stall_cnt
);

   // Reset payload is truncated or zero-extended to the stage width
   localparam logic [WIDTH-1:0] MAIN_RST = WIDTH'(RESET_VAL);
   localparam occ_e             OCC_RST  = RESET_VALID ? OCC_ONE : OCC_EMPTY;

   occ_e             occ_q;
   occ_e             occ_d;
   logic [WIDTH-1:0] main_q;
   logic [WIDTH-1:0] skid_q;
   logic             push;
   logic             pop;
   logic             accept;
   logic             stall_inc;
   logic             load_main_in;
   logic             load_main_skid;
   logic             load_skid;

   // Occupancy state and registered in_ready; in_ready is precomputed from the next state
   // so upstream never sees a combinational path through this stage
   always_ff @(posedge CLK) begin
      if (RST) begin
         occ_q    <= OCC_RST;
         in_ready <= 1'b1;
      end else begin
         occ_q    <= occ_d;
         in_ready <= (occ_d != OCC_FULL);
      end
   end

   // Next occupancy: flush empties the stage and overrides any push or pop
   always_comb begin
      occ_d = occ_q;
      if (Flush) begin
         occ_d = OCC_EMPTY;
      end else begin
         case (occ_q)
            OCC_EMPTY: if (push) occ_d = OCC_ONE;
            OCC_ONE: begin
               if (push && !pop)      occ_d = OCC_FULL;
               else if (pop && !push) occ_d = OCC_EMPTY;
            end
            OCC_FULL:  if (pop) occ_d = OCC_ONE;
            default:   occ_d = OCC_EMPTY;
         endcase
      end
   end

   // Handshake decode and payload load enables; a stall looks like downstream not ready
   always_comb begin
      out_valid      = (occ_q != OCC_EMPTY);
      accept         = out_valid & out_ready & !Stall;
      pop            = accept;
      push           = in_valid & in_ready;
      stall_inc      = out_valid & !accept;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      if (!Flush) begin
         case (occ_q)
            OCC_EMPTY: load_main_in = push;
            OCC_ONE: begin
               load_main_in = push & pop;
               load_skid    = push & !pop;
            end
            OCC_FULL:  load_main_skid = pop;
            default: ;
         endcase
      end
   end

   // Main (head) register drives out_data directly; it alone carries a reset value
   always_ff @(posedge CLK) begin
      if (RST) begin
         main_q <= MAIN_RST;
      end else if (load_main_in) begin
         main_q <= in_data;
      end else if (load_main_skid) begin
         main_q <= skid_q;
      end
   end

   // Skid register catches the beat accepted while the head is blocked
   always_ff @(posedge CLK) begin
      if (load_skid) begin
         skid_q <= in_data;
      end
   end

   assign out_data = main_q;

   pipe_sat_counter #(
      .CNT_W (CNT_W)
   ) u_stall_cnt (
      .CLK   (CLK),
      .RST   (RST),
      .inc   (stall_inc),
      .count (stall_cnt)
   );

endmodule

// File: tb/tb_pipe_reg_skid.sv
// tb/tb_pipe_reg_skid.sv - randomized and directed bench for pipe_reg_skid against a queue model
module tb_pipe_reg_skid;

   logic        CLK;
   logic        RST;
   logic        Stall;
   logic        Flush;
   logic        in_valid;
   logic [31:0] in_data;
   logic        out_ready;

   logic        in_ready0;
   logic        out_valid0;
   logic [31:0] out_data0;
   logic [15:0] stall_cnt0;

   logic        in_ready1;
   logic        out_valid1;
   logic [7:0]  out_data1;
   logic [1:0]  stall_cnt1;

   int n_chk;
   int n_pass;

   pipe_reg_skid dut0 (
      .CLK       (CLK),
      .RST       (RST),
      .Stall     (Stall),
      .Flush     (Flush),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready0),
      .out_valid (out_valid0),
      .out_data  (out_data0),
      .out_ready (out_ready),
      .stall_cnt (stall_cnt0)
   );

   pipe_reg_skid #(
      .WIDTH       (8),
      .RESET_VAL   (32'h00400030),
      .RESET_VALID (1'b0),
      .CNT_W       (2)
   ) dut1 (
      .CLK       (CLK),
      .RST       (RST),
      .Stall     (Stall),
      .Flush     (Flush),
      .in_valid  (in_valid),
      .in_data   (in_data[7:0]),
      .in_ready  (in_ready1),
      .out_valid (out_valid1),
      .out_data  (out_data1),
      .out_ready (out_ready),
      .stall_cnt (stall_cnt1)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%h required=%h", name, act, exp);
   endtask

   // Model: each instance is an ordered list of at most two held entries plus a stall count
   logic [31:0] m_e   [2][2];
   int          m_n   [2];
   int          m_cnt [2];
   bit          model_ok;
   bit          m_acc;
   bit          m_psh;

   function automatic logic [31:0] cfg_mask(int i);
      return (i == 0) ? 32'hFFFF_FFFF : 32'h0000_00FF;
   endfunction
   function automatic int cfg_rv(int i);
      return (i == 0) ? 1 : 0;
   endfunction
   function automatic int cfg_cmax(int i);
      return (i == 0) ? 65535 : 3;
   endfunction

   initial model_ok = 1'b0;

   always @(posedge CLK) begin
      for (int i = 0; i < 2; i++) begin
         if (RST) begin
            m_n[i]    = cfg_rv(i);
            m_e[i][0] = 32'h00400030 & cfg_mask(i);
            m_cnt[i]  = 0;
         end else if (model_ok) begin
            m_acc = (m_n[i] > 0) && out_ready && !Stall;
            m_psh = in_valid && (m_n[i] < 2);
            if ((m_n[i] > 0) && !m_acc && (m_cnt[i] < cfg_cmax(i))) m_cnt[i]++;
            if (Flush) begin
               m_n[i] = 0;
            end else begin
               if (m_acc) begin
                  m_e[i][0] = m_e[i][1];
                  m_n[i]--;
               end
               if (m_psh) begin
                  m_e[i][m_n[i]] = in_data & cfg_mask(i);
                  m_n[i]++;
               end
            end
         end
      end
      if (RST) model_ok = 1'b1;
   end

   // Compare both instances against the model on every falling edge
   always @(negedge CLK) begin
      if (model_ok) begin
         chk("out_valid0", {31'd0, out_valid0}, {31'd0, m_n[0] > 0});
         chk("in_ready0",  {31'd0, in_ready0},  {31'd0, m_n[0] < 2});
         chk("stall_cnt0", {16'd0, stall_cnt0}, m_cnt[0]);
         if (m_n[0] > 0) chk("out_data0", out_data0, m_e[0][0]);
         chk("out_valid1", {31'd0, out_valid1}, {31'd0, m_n[1] > 0});
         chk("in_ready1",  {31'd0, in_ready1},  {31'd0, m_n[1] < 2});
         chk("stall_cnt1", {30'd0, stall_cnt1}, m_cnt[1]);
         if (m_n[1] > 0) chk("out_data1", {24'd0, out_data1}, m_e[1][0]);
      end
   end

   initial begin
      int base;
      n_chk     = 0;
      n_pass    = 0;
      RST       = 1'b1;
      Stall     = 1'b0;
      Flush     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 32'd0;
      out_ready = 1'b0;

      // Reset held two cycles
      repeat (2) @(negedge CLK);
      chk("rst_ov0",  {31'd0, out_valid0}, 32'd1);
      chk("rst_od0",  out_data0, 32'h00400030);
      chk("rst_ir0",  {31'd0, in_ready0}, 32'd1);
      chk("rst_sc0",  {16'd0, stall_cnt0}, 32'd0);
      chk("rst_ov1",  {31'd0, out_valid1}, 32'd0);
      chk("rst_ir1",  {31'd0, in_ready1}, 32'd1);
      chk("rst_mdl",  m_e[1][0], 32'h30);
      RST = 1'b0;

      // Streaming at full rate
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1;
         in_data  = 32'h10 + 32'(4 * k);
         @(negedge CLK);
         chk("stream_od", out_data0, 32'h10 + 32'(4 * k));
         chk("stream_ir", {31'd0, in_ready0}, 32'd1);
      end
      in_valid = 1'b0;
      @(negedge CLK);
      chk("stream_drain", {31'd0, out_valid0}, 32'd0);

      // Backpressure fills the skid, third beat held upstream
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'hA;
      @(negedge CLK);
      in_data = 32'hB;
      @(negedge CLK);
      chk("bp_full_ir", {31'd0, in_ready0}, 32'd0);
      in_data = 32'hC;
      @(negedge CLK);
      chk("bp_hold_od", out_data0, 32'hA);
      out_ready = 1'b1;
      @(negedge CLK);
      chk("bp_pop_b", out_data0, 32'hB);
      @(negedge CLK);
      chk("bp_pop_c", out_data0, 32'hC);
      in_valid = 1'b0;
      @(negedge CLK);
      chk("bp_empty", {31'd0, out_valid0}, 32'd0);
      chk("bp_sc0",   {16'd0, stall_cnt0}, 32'd2);

      // Stall with downstream ready: output frozen, counter advances
      in_valid = 1'b1;
      in_data  = 32'h55;
      @(negedge CLK);
      in_valid = 1'b0;
      Stall    = 1'b1;
      base     = m_cnt[0];
      repeat (5) @(negedge CLK);
      chk("stall_od",  out_data0, 32'h55);
      chk("stall_inc", {16'd0, stall_cnt0}, 32'(base + 5));
      chk("stall_lit", {16'd0, stall_cnt0}, 32'd7);
      chk("stall_sat", {30'd0, stall_cnt1}, 32'd3);
      Stall = 1'b0;
      @(negedge CLK);

      // Flush while FULL with a beat offered
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'h60;
      @(negedge CLK);
      in_data = 32'h64;
      @(negedge CLK);
      Flush   = 1'b1;
      in_data = 32'h20;
      @(negedge CLK);
      chk("flush_ov", {31'd0, out_valid0}, 32'd0);
      chk("flush_ir", {31'd0, in_ready0}, 32'd1);
      Flush    = 1'b0;
      in_valid = 1'b0;
      @(negedge CLK);
      chk("flush_no20", {31'd0, out_valid0}, 32'd0);

      // Flush beats an accepted push in ONE
      in_valid = 1'b1;
      in_data  = 32'h30;
      @(negedge CLK);
      Flush   = 1'b1;
      in_data = 32'h20;
      @(negedge CLK);
      chk("flush1_ov", {31'd0, out_valid0}, 32'd0);
      Flush    = 1'b0;
      in_valid = 1'b0;
      @(negedge CLK);
      chk("flush1_no20", {31'd0, out_valid0}, 32'd0);

      // Reset wins over flush while FULL
      in_valid = 1'b1;
      in_data  = 32'h70;
      @(negedge CLK);
      in_data = 32'h74;
      @(negedge CLK);
      RST      = 1'b1;
      Flush    = 1'b1;
      in_valid = 1'b0;
      @(negedge CLK);
      chk("rf_ov0", {31'd0, out_valid0}, 32'd1);
      chk("rf_od0", out_data0, 32'h00400030);
      chk("rf_ir0", {31'd0, in_ready0}, 32'd1);
      chk("rf_sc0", {16'd0, stall_cnt0}, 32'd0);
      chk("rf_ov1", {31'd0, out_valid1}, 32'd0);
      chk("rf_sc1", {30'd0, stall_cnt1}, 32'd0);
      RST   = 1'b0;
      Flush = 1'b0;

      // Randomized traffic
      for (int k = 0; k < 4000; k++) begin
         in_valid  = ($urandom_range(3) != 0);
         in_data   = $urandom;
         out_ready = ($urandom_range(3) != 0);
         Stall     = ($urandom_range(7) == 0);
         Flush     = ($urandom_range(31) == 0);
         RST       = ($urandom_range(255) == 0);
         @(negedge CLK);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
